// File: rtl/memory_stage.sv
// Memory stage of a five-stage pipeline: data memory access, branch resolution
// and the memory/writeback pipeline register.
// Compile option: SUBWORD_ACCESS_EN enables byte/halfword loads and stores
// decoded from funct3_M; without it every access is a full 32-bit word.
module memory_stage #(
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ALU_zero_M,
    input  logic [31:0] ALU_result_M,
    input  logic [31:0] register_file_srcB_M,
    input  logic [4:0]  register_file_WA_M,
    input  logic [31:0] PC_branch_M,
    input  logic        ctrl_register_file_WE_M,
    input  logic        ctrl_data_memory_WE_M,
    input  logic        ctrl_result_M,
    input  logic        ctrl_branch_M,
    input  logic [2:0]  funct3_M,
    output logic        PC_src_M,
    output logic [31:0] PC_branch_out_M,
    output logic [31:0] ALU_result_W,
    output logic [31:0] read_data_W,
    output logic [4:0]  register_file_WA_W,
    output logic        ctrl_register_file_WE_W,
    output logic        ctrl_result_W
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);

    // Data memory; contents survive reset and start out cleared.
    logic [31:0] mem_q [DMEM_WORDS] = '{default: 32'h0};

    logic [AW-1:0] mem_idx;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    logic [31:0] ALU_result_d, ALU_result_q;
    logic [31:0] read_data_d, read_data_q;
    logic [4:0]  register_file_WA_d, register_file_WA_q;
    logic        ctrl_register_file_WE_d, ctrl_register_file_WE_q;
    logic        ctrl_result_d, ctrl_result_q;

    // Upper address bits alias onto the array; funct3 is unused in word-only builds.
    logic unused_bits;
    assign unused_bits = ^{ALU_result_M[31:AW+2], ALU_result_M[1:0], funct3_M};

    // Branch resolution and word index; purely combinational, independent of reset.
    always_comb begin
        PC_src_M        = ctrl_branch_M & ALU_zero_M;
        PC_branch_out_M = PC_branch_M;
        mem_idx         = ALU_result_M[AW+1:2];
        rd_word         = mem_q[mem_idx];
    end

`ifdef SUBWORD_ACCESS_EN
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Load lane extraction and extension; unlisted codes read a full word.
    always_comb begin
        rd_byte   = rd_word[8*ALU_result_M[1:0] +: 8];
        rd_half   = ALU_result_M[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        unique case (funct3_M)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Store lane enables; the data is replicated so every lane sees its value.
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = register_file_srcB_M;
        unique case (funct3_M)
            3'b000: begin
                wr_be   = 4'b0001 << ALU_result_M[1:0];
                wr_data = {4{register_file_srcB_M[7:0]}};
            end
            3'b001: begin
                wr_be   = ALU_result_M[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{register_file_srcB_M[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = register_file_srcB_M;
            end
        endcase
    end
`else
    // Word-only access: funct3 is ignored.
    always_comb begin
        load_data = rd_word;
        wr_be     = 4'b1111;
        wr_data   = register_file_srcB_M;
    end
`endif

    // Memory write; the read above still sees the old word this cycle.
    always_ff @(posedge clk) begin
        if (!rst && ctrl_data_memory_WE_M) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Next state of the writeback pipeline register; reset forces zeros.
    always_comb begin
        ALU_result_d            = ALU_result_M;
        read_data_d             = load_data;
        register_file_WA_d      = register_file_WA_M;
        ctrl_register_file_WE_d = ctrl_register_file_WE_M;
        ctrl_result_d           = ctrl_result_M;
        if (rst) begin
            ALU_result_d            = 32'h0;
            read_data_d             = 32'h0;
            register_file_WA_d      = 5'h0;
            ctrl_register_file_WE_d = 1'b0;
            ctrl_result_d           = 1'b0;
        end
    end

    // Writeback pipeline register.
    always_ff @(posedge clk) begin
        ALU_result_q            <= ALU_result_d;
        read_data_q             <= read_data_d;
        register_file_WA_q      <= register_file_WA_d;
        ctrl_register_file_WE_q <= ctrl_register_file_WE_d;
        ctrl_result_q           <= ctrl_result_d;
    end

    // Drive the writeback outputs from the register.
    always_comb begin
        ALU_result_W            = ALU_result_q;
        read_data_W             = read_data_q;
        register_file_WA_W      = register_file_WA_q;
        ctrl_register_file_WE_W = ctrl_register_file_WE_q;
        ctrl_result_W           = ctrl_result_q;
    end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver pushes the expected writeback
// contents for every driven cycle, the monitor pops and compares after each edge.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ALU_zero_M;
    logic [31:0] ALU_result_M;
    logic [31:0] register_file_srcB_M;
    logic [4:0]  register_file_WA_M;
    logic [31:0] PC_branch_M;
    logic        ctrl_register_file_WE_M;
    logic        ctrl_data_memory_WE_M;
    logic        ctrl_result_M;
    logic        ctrl_branch_M;
    logic [2:0]  funct3_M;
    logic        PC_src_M;
    logic [31:0] PC_branch_out_M;
    logic [31:0] ALU_result_W;
    logic [31:0] read_data_W;
    logic [4:0]  register_file_WA_W;
    logic        ctrl_register_file_WE_W;
    logic        ctrl_result_W;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wa;
        logic        we;
        logic        res;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad = 0;

    memory_stage #(.DMEM_WORDS(64)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ALU_zero_M              (ALU_zero_M),
        .ALU_result_M            (ALU_result_M),
        .register_file_srcB_M    (register_file_srcB_M),
        .register_file_WA_M      (register_file_WA_M),
        .PC_branch_M             (PC_branch_M),
        .ctrl_register_file_WE_M (ctrl_register_file_WE_M),
        .ctrl_data_memory_WE_M   (ctrl_data_memory_WE_M),
        .ctrl_result_M           (ctrl_result_M),
        .ctrl_branch_M           (ctrl_branch_M),
        .funct3_M                (funct3_M),
        .PC_src_M                (PC_src_M),
        .PC_branch_out_M         (PC_branch_out_M),
        .ALU_result_W            (ALU_result_W),
        .read_data_W             (read_data_W),
        .register_file_WA_W      (register_file_WA_W),
        .ctrl_register_file_WE_W (ctrl_register_file_WE_W),
        .ctrl_result_W           (ctrl_result_W)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One pipeline cycle of stimulus, driven on the falling edge.
    task automatic step(input logic r, input logic [31:0] alu, input logic [31:0] srcb,
                        input logic [4:0] wa, input logic we_rf, input logic we_dm,
                        input logic res, input logic [2:0] f3, input logic [31:0] exp_rd,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst                     = r;
        ALU_result_M            = alu;
        register_file_srcB_M    = srcb;
        register_file_WA_M      = wa;
        ctrl_register_file_WE_M = we_rf;
        ctrl_data_memory_WE_M   = we_dm;
        ctrl_result_M           = res;
        funct3_M                = f3;
        e.rd  = r ? 32'h0 : exp_rd;
        e.alu = r ? 32'h0 : alu;
        e.wa  = r ? 5'h0 : wa;
        e.we  = r ? 1'b0 : we_rf;
        e.res = r ? 1'b0 : res;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic br(input logic b, input logic z, input logic [31:0] pc,
                      input logic exp_src, input string nm);
        ctrl_branch_M = b;
        ALU_zero_M    = z;
        PC_branch_M   = pc;
        #1;
        chk({nm, ".src"}, {31'h0, PC_src_M}, {31'h0, exp_src});
        chk({nm, ".tgt"}, PC_branch_out_M, pc);
    endtask

    // Monitor: one scoreboard entry per edge once the driver has started.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                chk({nm, ".rd"},  read_data_W, e.rd);
                chk({nm, ".alu"}, ALU_result_W, e.alu);
                chk({nm, ".wa"},  {27'h0, register_file_WA_W}, {27'h0, e.wa});
                chk({nm, ".we"},  {31'h0, ctrl_register_file_WE_W}, {31'h0, e.we});
                chk({nm, ".res"}, {31'h0, ctrl_result_W}, {31'h0, e.res});
            end
        end
    end

    initial begin
        logic [31:0] x_lb, x_lbu, x_lh, x_lhu, x_sb_old, x_after_sb, x_sh_old, x_after_sh;
`ifdef SUBWORD_ACCESS_EN
        x_lb = 32'hFFFFFF80; x_lbu = 32'h00000080; x_lh = 32'hFFFF80FF; x_lhu = 32'h00007F01;
        x_sb_old = 32'h0000007F; x_after_sb = 32'h80FFAB01;
        x_sh_old = 32'hFFFF80FF; x_after_sh = 32'hBEEFAB01;
`else
        x_lb = 32'h80FF7F01; x_lbu = 32'h80FF7F01; x_lh = 32'h80FF7F01; x_lhu = 32'h80FF7F01;
        x_sb_old = 32'h80FF7F01; x_after_sb = 32'h000000AB;
        x_sh_old = 32'h000000AB; x_after_sh = 32'h1234BEEF;
`endif
        rst = 1'b1; ALU_zero_M = 1'b0; ALU_result_M = '0; register_file_srcB_M = '0;
        register_file_WA_M = '0; PC_branch_M = '0; ctrl_register_file_WE_M = 1'b0;
        ctrl_data_memory_WE_M = 1'b0; ctrl_result_M = 1'b0; ctrl_branch_M = 1'b0;
        funct3_M = 3'b010;

        //   rst  alu           srcB          wa  rf  dm  res f3      exp_rd
        step(1, 32'h0000_0000, 32'h0,        0,  0,  0,  0, 3'b010, 32'h0,        "reset");
        step(0, 32'h0000_0010, 32'hDEADBEEF, 0,  0,  1,  0, 3'b010, 32'h0,        "sw10");
        step(0, 32'h0000_0010, 32'h0,        5,  1,  0,  1, 3'b010, 32'hDEADBEEF, "lw10");
        step(0, 32'h0000_0010, 32'h11111111, 7,  1,  1,  0, 3'b010, 32'hDEADBEEF, "sw10_rf");
        step(0, 32'h0000_0010, 32'h0,        9,  1,  0,  1, 3'b010, 32'h11111111, "lw10b");
        step(0, 32'h0000_0100, 32'h00001234, 0,  0,  1,  0, 3'b010, 32'h0,        "sw100");
        step(0, 32'h0000_0000, 32'h0,        2,  1,  0,  1, 3'b010, 32'h00001234, "lw000");
        step(1, 32'h0000_0008, 32'hCAFEF00D, 3,  1,  1,  1, 3'b010, 32'h0,        "rstsw");
        br(1, 1, 32'h40, 1, "br_rst");
        step(0, 32'h0000_0008, 32'h0,        4,  1,  0,  1, 3'b010, 32'h0,        "lw08");
        br(1, 1, 32'h40, 1, "br_t");
        br(1, 0, 32'h40, 0, "br_nz");
        br(0, 1, 32'h1230, 0, "br_nb");
        ctrl_branch_M = 1'b0;
        step(0, 32'h0000_0010, 32'h0,        4,  1,  0,  1, 3'b010, 32'h11111111, "lw10c");
        step(0, 32'h0000_0020, 32'h80FF7F01, 0,  0,  1,  0, 3'b010, 32'h0,        "sw20");
        step(0, 32'h0000_0023, 32'h0,        1,  1,  0,  1, 3'b000, x_lb,         "lb23");
        step(0, 32'h0000_0023, 32'h0,        1,  1,  0,  1, 3'b100, x_lbu,        "lbu23");
        step(0, 32'h0000_0022, 32'h0,        1,  1,  0,  1, 3'b001, x_lh,         "lh22");
        step(0, 32'h0000_0020, 32'h0,        1,  1,  0,  1, 3'b101, x_lhu,        "lhu20");
        step(0, 32'h0000_0023, 32'h0,        1,  1,  0,  1, 3'b001, x_lh,         "lh23");
        step(0, 32'h0000_0021, 32'h000000AB, 0,  0,  1,  0, 3'b000, x_sb_old,     "sb21");
        step(0, 32'h0000_0020, 32'h0,        6,  1,  0,  1, 3'b010, x_after_sb,   "lw20a");
        step(0, 32'h0000_0022, 32'h1234BEEF, 0,  0,  1,  0, 3'b001, x_sh_old,     "sh22");
        step(0, 32'h0000_0020, 32'h0,        6,  1,  0,  1, 3'b010, x_after_sh,   "lw20b");
        step(0, 32'h0000_0020, 32'h55667788, 0,  0,  1,  0, 3'b011, x_after_sh,   "sw011");
        step(0, 32'h0000_0020, 32'h0,        8,  1,  0,  1, 3'b110, 32'h55667788, "lw110");
        step(0, 32'h0000_0000, 32'h0,        0,  0,  0,  0, 3'b010, 32'h00001234, "idle");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
